mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single core memory port between two requesters: m0 (IFU instruction
//  fetch) and m1 (EXU load/store unit), using the req_valid/req_ready and
//  rsp_valid/rsp_ready handshakes. Grants in the same cycle as the request, so it
//  adds no request latency. Tracks up to OUTSTANDING accepted requests and routes
//  each in-order response back to the master that issued it.
// PARAMETERS
//  OUTSTANDING   2   max accepted-but-unanswered requests (owner-ID FIFO depth, >=1)
//  STARVE_LIMIT  4   consecutive m1 grants while m0 waits before m0 is forced a grant
// PORTS
//  clk              in   1   clock
//  rst              in   1   async reset, active high
//  mN_req_valid_i   in   1   master N request valid (N=0,1; same set per master)
//  mN_req_ready_o   out  1   master N request accepted this cycle
//  mN_addr_i        in   32  master N address
//  mN_wdata_i       in   32  master N write data
//  mN_we_i          in   1   master N write enable
//  mN_sel_i         in   4   master N byte select
//  mN_rsp_valid_o   out  1   response valid to master N
//  mN_rsp_ready_i   in   1   master N accepts response
//  mN_rdata_o       out  32  response data (s_rdata_i broadcast)
//  s_req_valid_o    out  1   request valid to memory
//  s_req_ready_i    in   1   memory accepts request
//  s_addr_o/s_wdata_o/s_we_o/s_sel_o  out 32/32/1/4  muxed request fields of granted master
//  s_rsp_valid_i    in   1   memory response valid
//  s_rsp_ready_o    out  1   arbiter accepts response
//  s_rdata_i        in   32  memory response data
//  busy_o           out  1   FIFO non-empty (any request outstanding)
//  rsp_err_o        out  1   1-cycle pulse: s_rsp_valid_i while FIFO empty
// BEHAVIOUR
//  Reset: FIFO empty, lock clear, starve counter 0, rsp_err_o 0. While rst is high,
//  all valid/ready outputs = 0 and s_* request fields = 0. Outstanding entries are
//  discarded on reset; the memory must be reset with the arbiter.
//  Arbitration (comb), evaluated only when unlocked and FIFO not full:
//   m1 wins over m0, except m0 wins when starve_cnt == STARVE_LIMIT.
//  s_req_valid_o = winner's req_valid; s_* fields = winner's fields;
//  winner's req_ready_o = s_req_ready_i; loser's req_ready_o = 0.
//  Lock: if s_req_valid_o=1 and s_req_ready_i=0, register the winner; the grant stays
//   with that master until the handshake completes (stable valid/fields). Lock clears
//   on handshake.
//  FIFO full: s_req_valid_o=0, both req_ready_o=0. A pop in the same cycle does NOT
//   unblock a push (no rsp->req comb path); the push waits one cycle.
//  Accept (s_req_valid_o & s_req_ready_i): push granted ID (0/1) into the FIFO.
//  Starve counter: +1 on an m1 accept while m0_req_valid_i=1 (saturates at
//   STARVE_LIMIT); cleared on m0 accept or when m0_req_valid_i=0.
//  Response: head ID selects the master; that mN_rsp_valid_o = s_rsp_valid_i, other = 0;
//   s_rsp_ready_o = head master's rsp_ready_i; pop on s_rsp_valid_i & s_rsp_ready_o.
//   Responses are in order. The earliest response is the cycle after acceptance;
//   same-cycle (zero-latency) responses are not supported.
//  FIFO empty: s_rsp_ready_o=0, both rsp_valid_o=0; s_rsp_valid_i=1 -> rsp_err_o=1
//   next cycle (registered), response ignored.
//  Simultaneous push and pop (not full): both occur; the count is unchanged.
//  FIFO pointers wrap modulo OUTSTANDING; full = count==OUTSTANDING.
// TESTING
//  T1 m0 only, addr 0x100, ready=1, rsp 1 cycle later rdata 0xDEADBEEF -> m0_rsp_valid_o=1 with that data, busy_o 1->0.
//  T2 m0,m1 both valid, s_req_ready_i=1 -> m1 granted; m0 granted after 4 m1 accepts (STARVE_LIMIT=4).
//  T3 m0 valid, s_req_ready_i=0 for 3 cycles, m1 raises valid -> grant stays with m0; fields stable until accept.
//  T4 accept m1 then m0, no responses -> 3rd request blocked (full); rsp for m1 then m0 are routed in order;
//      on pop-while-full, the push occurs one cycle later.
//  T5 s_rsp_valid_i with FIFO empty -> rsp_err_o pulses 1 cycle, no mN_rsp_valid_o.
//  T6 assert rst with 2 outstanding -> busy_o=0, all valid/ready outputs 0 immediately (async).

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Bundle of every signal between the two requesters (m0 = IFU fetch, m1 = EXU
// load/store), the shared memory port and the arbiter.
// Handshake rule for every valid/ready pair: a transfer happens in the cycle
// where valid and ready are both 1. Once valid is raised, the source holds
// valid and its fields steady until that transfer. Ready may depend on valid.
// The slave modport is the arbiter's view; the master modport is the
// environment's view (requesters + memory), the exact mirror.
interface mem_port_arbiter_if;
  logic        m0_req_valid_i;
  logic        m0_req_ready_o;
  logic [31:0] m0_addr_i;
  logic [31:0] m0_wdata_i;
  logic        m0_we_i;
  logic [3:0]  m0_sel_i;
  logic        m0_rsp_valid_o;
  logic        m0_rsp_ready_i;
  logic [31:0] m0_rdata_o;

  logic        m1_req_valid_i;
  logic        m1_req_ready_o;
  logic [31:0] m1_addr_i;
  logic [31:0] m1_wdata_i;
  logic        m1_we_i;
  logic [3:0]  m1_sel_i;
  logic        m1_rsp_valid_o;
  logic        m1_rsp_ready_i;
  logic [31:0] m1_rdata_o;

  logic        s_req_valid_o;
  logic        s_req_ready_i;
  logic [31:0] s_addr_o;
  logic [31:0] s_wdata_o;
  logic        s_we_o;
  logic [3:0]  s_sel_o;
  logic        s_rsp_valid_i;
  logic        s_rsp_ready_o;
  logic [31:0] s_rdata_i;

  logic        busy_o;
  logic        rsp_err_o;
  logic [1:0]  dbg_state_o;

  modport slave (
    input  m0_req_valid_i, m0_addr_i, m0_wdata_i, m0_we_i, m0_sel_i, m0_rsp_ready_i,
    input  m1_req_valid_i, m1_addr_i, m1_wdata_i, m1_we_i, m1_sel_i, m1_rsp_ready_i,
    input  s_req_ready_i, s_rsp_valid_i, s_rdata_i,
    output m0_req_ready_o, m0_rsp_valid_o, m0_rdata_o,
    output m1_req_ready_o, m1_rsp_valid_o, m1_rdata_o,
    output s_req_valid_o, s_addr_o, s_wdata_o, s_we_o, s_sel_o, s_rsp_ready_o,
    output busy_o, rsp_err_o, dbg_state_o
  );

  modport master (
    output m0_req_valid_i, m0_addr_i, m0_wdata_i, m0_we_i, m0_sel_i, m0_rsp_ready_i,
    output m1_req_valid_i, m1_addr_i, m1_wdata_i, m1_we_i, m1_sel_i, m1_rsp_ready_i,
    output s_req_ready_i, s_rsp_valid_i, s_rdata_i,
    input  m0_req_ready_o, m0_rsp_valid_o, m0_rdata_o,
    input  m1_req_ready_o, m1_rsp_valid_o, m1_rdata_o,
    input  s_req_valid_o, s_addr_o, s_wdata_o, s_we_o, s_sel_o, s_rsp_ready_o,
    input  busy_o, rsp_err_o, dbg_state_o
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-master arbiter for the single core memory port. The grant is
// combinational (no added request latency). m1 has priority unless m0 has been
// starved for STARVE_LIMIT consecutive m1 accepts. A stalled grant is locked
// until its handshake completes. An owner-ID FIFO routes in-order responses
// back to the master that issued the request.
module mem_port_arbiter #(
  parameter int OUTSTANDING  = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  mem_port_arbiter_if.slave bus
);
  localparam int PW = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
  localparam int CW = $clog2(OUTSTANDING + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  // dbg_state_o exposes this encoding
  typedef enum logic [1:0] {
    ARB_OPEN    = 2'd0,
    ARB_LOCK_M0 = 2'd1,
    ARB_LOCK_M1 = 2'd2
  } arb_state_e;

  arb_state_e             state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
  logic [OUTSTANDING-1:0] owner_q, owner_d;   // 1 = slot issued by m1
  logic [SW-1:0]          starve_q, starve_d;
  logic                   rsp_err_q, rsp_err_d;

  logic full, empty, win_m1, grant_valid, accept, head_m1, rsp_ready, pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(OUTSTANDING - 1)) ? '0 : p + PW'(1);
  endfunction

  // Winner selection: a lock pins the grant, otherwise m1 unless m0 is starved
  always_comb begin
    full  = (cnt_q == CW'(OUTSTANDING));
    empty = (cnt_q == '0);
    case (state_q)
      ARB_LOCK_M0: win_m1 = 1'b0;
      ARB_LOCK_M1: win_m1 = 1'b1;
      default:     win_m1 = bus.m1_req_valid_i &&
                            !(bus.m0_req_valid_i && (starve_q == SW'(STARVE_LIMIT)));
    endcase
    // A pop this cycle never frees room for a push: full uses the registered count
    grant_valid = !full && (win_m1 ? bus.m1_req_valid_i : bus.m0_req_valid_i);
    accept      = grant_valid && bus.s_req_ready_i;
    head_m1     = owner_q[rd_ptr_q];
    rsp_ready   = !empty && (head_m1 ? bus.m1_rsp_ready_i : bus.m0_rsp_ready_i);
    pop         = bus.s_rsp_valid_i && rsp_ready;
  end

  // Request side: forward winner, everything forced to 0 while in reset
  assign bus.s_req_valid_o  = !rst && grant_valid;
  assign bus.m0_req_ready_o = !rst && !full && !win_m1 && bus.s_req_ready_i;
  assign bus.m1_req_ready_o = !rst && !full &&  win_m1 && bus.s_req_ready_i;
  assign bus.s_addr_o       = rst ? '0 : (win_m1 ? bus.m1_addr_i  : bus.m0_addr_i);
  assign bus.s_wdata_o      = rst ? '0 : (win_m1 ? bus.m1_wdata_i : bus.m0_wdata_i);
  assign bus.s_we_o         = !rst && (win_m1 ? bus.m1_we_i : bus.m0_we_i);
  assign bus.s_sel_o        = rst ? '0 : (win_m1 ? bus.m1_sel_i   : bus.m0_sel_i);

  // Response side: the FIFO head decides which master sees the response
  assign bus.m0_rsp_valid_o = !rst && !empty && !head_m1 && bus.s_rsp_valid_i;
  assign bus.m1_rsp_valid_o = !rst && !empty &&  head_m1 && bus.s_rsp_valid_i;
  assign bus.s_rsp_ready_o  = !rst && rsp_ready;
  assign bus.m0_rdata_o     = bus.s_rdata_i;
  assign bus.m1_rdata_o     = bus.s_rdata_i;
  assign bus.busy_o         = !rst && !empty;
  assign bus.rsp_err_o      = rsp_err_q;
  assign bus.dbg_state_o    = state_q;

  // Lock FSM: hold a stalled grant until its handshake completes
  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB_OPEN: if (grant_valid && !bus.s_req_ready_i)
                  state_d = win_m1 ? ARB_LOCK_M1 : ARB_LOCK_M0;
      default:  if (accept) state_d = ARB_OPEN;
    endcase
  end

  // Owner FIFO, starvation counter and empty-response error pulse
  always_comb begin
    owner_d   = owner_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    cnt_d     = cnt_q;
    starve_d  = starve_q;
    rsp_err_d = bus.s_rsp_valid_i && empty;
    if (accept) begin
      owner_d[wr_ptr_q] = win_m1;
      wr_ptr_d          = ptr_inc(wr_ptr_q);
    end
    if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
    case ({accept, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
    if (!bus.m0_req_valid_i || (accept && !win_m1))
      starve_d = '0;
    else if (accept && win_m1 && (starve_q != SW'(STARVE_LIMIT)))
      starve_d = starve_q + SW'(1);
  end

  // State registers, async active-high reset discards outstanding entries
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ARB_OPEN;
      cnt_q     <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      owner_q   <= '0;
      starve_q  <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      owner_q   <= owner_d;
      starve_q  <= starve_d;
      rsp_err_q <= rsp_err_d;
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios followed by random traffic,
// every cycle compared against a queue-based reference model of the arbiter.
module tb_mem_port_arbiter;
  localparam int OUT   = 2;
  localparam int LIMIT = 4;

  logic clk;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  // reference model state
  logic [0:0] exp_q[$];     // owner IDs of outstanding requests, oldest first
  int         lock_m  = -1; // master holding a stalled grant, -1 = none
  int         starve_m = 0;
  logic       err_m   = 1'b0;
  logic       last_acc;
  int         last_win;

  mem_port_arbiter_if bus ();

  mem_port_arbiter #(.OUTSTANDING(OUT), .STARVE_LIMIT(LIMIT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial begin
    #2000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive_idle();
    bus.m0_req_valid_i = 1'b0; bus.m0_addr_i = '0; bus.m0_wdata_i = '0;
    bus.m0_we_i = 1'b0; bus.m0_sel_i = '0; bus.m0_rsp_ready_i = 1'b0;
    bus.m1_req_valid_i = 1'b0; bus.m1_addr_i = '0; bus.m1_wdata_i = '0;
    bus.m1_we_i = 1'b0; bus.m1_sel_i = '0; bus.m1_rsp_ready_i = 1'b0;
    bus.s_req_ready_i = 1'b0; bus.s_rsp_valid_i = 1'b0; bus.s_rdata_i = '0;
  endtask

  task automatic model_reset();
    exp_q.delete();
    lock_m = -1; starve_m = 0; err_m = 1'b0;
  endtask

  // let inputs settle, compare all outputs with the model, advance the model
  task automatic settle();
    bit full, empty, gv, head, srr;
    int win;
    #2;
    full  = (exp_q.size() == OUT);
    empty = (exp_q.size() == 0);
    if (lock_m >= 0) win = lock_m;
    else if (bus.m0_req_valid_i && starve_m == LIMIT) win = 0;
    else if (bus.m1_req_valid_i) win = 1;
    else win = 0;
    gv = !full && ((win == 1) ? bus.m1_req_valid_i : bus.m0_req_valid_i);
    chk("s_req_valid", 32'(bus.s_req_valid_o), 32'(gv));
    if (gv) begin
      chk("s_addr",  bus.s_addr_o,  (win == 1) ? bus.m1_addr_i  : bus.m0_addr_i);
      chk("s_wdata", bus.s_wdata_o, (win == 1) ? bus.m1_wdata_i : bus.m0_wdata_i);
      chk("s_we",  32'(bus.s_we_o),  32'((win == 1) ? bus.m1_we_i  : bus.m0_we_i));
      chk("s_sel", 32'(bus.s_sel_o), 32'((win == 1) ? bus.m1_sel_i : bus.m0_sel_i));
    end
    if (bus.m0_req_valid_i)
      chk("m0_req_ready", 32'(bus.m0_req_ready_o), 32'(gv && win == 0 && bus.s_req_ready_i));
    if (bus.m1_req_valid_i)
      chk("m1_req_ready", 32'(bus.m1_req_ready_o), 32'(gv && win == 1 && bus.s_req_ready_i));
    head = empty ? 1'b0 : exp_q[0];
    srr  = !empty && (head ? bus.m1_rsp_ready_i : bus.m0_rsp_ready_i);
    chk("m0_rsp_valid", 32'(bus.m0_rsp_valid_o), 32'(!empty && !head && bus.s_rsp_valid_i));
    chk("m1_rsp_valid", 32'(bus.m1_rsp_valid_o), 32'(!empty &&  head && bus.s_rsp_valid_i));
    chk("s_rsp_ready",  32'(bus.s_rsp_ready_o),  32'(srr));
    chk("m0_rdata", bus.m0_rdata_o, bus.s_rdata_i);
    chk("m1_rdata", bus.m1_rdata_o, bus.s_rdata_i);
    chk("busy",    32'(bus.busy_o),    32'(!empty));
    chk("rsp_err", 32'(bus.rsp_err_o), 32'(err_m));
    last_acc = gv && bus.s_req_ready_i;
    last_win = win;
    if (!empty && bus.s_rsp_valid_i && srr) void'(exp_q.pop_front());
    if (last_acc) exp_q.push_back(1'(win));
    if (last_acc) lock_m = -1;
    else if (gv) lock_m = win;
    if (!bus.m0_req_valid_i || (last_acc && win == 0)) starve_m = 0;
    else if (last_acc && win == 1 && starve_m < LIMIT) starve_m++;
    err_m = bus.s_rsp_valid_i && empty;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // answer every outstanding request, then one idle cycle
  task automatic drain();
    drive_idle();
    bus.m0_rsp_ready_i = 1'b1;
    bus.m1_rsp_ready_i = 1'b1;
    for (int k = 0; k < 8 && exp_q.size() > 0; k++) begin
      bus.s_rsp_valid_i = 1'b1;
      bus.s_rdata_i = $urandom;
      settle();
      tick();
    end
    drive_idle();
    settle();
    chk("drain_busy", 32'(bus.busy_o), 32'd0);
    tick();
  endtask

  initial begin
    bit pend0, pend1;
    drive_idle();
    model_reset();
    // reset: outputs forced low even with active inputs
    rst = 1'b1;
    bus.m0_req_valid_i = 1'b1; bus.m1_req_valid_i = 1'b1; bus.m1_addr_i = 32'hABCD0000;
    bus.s_req_ready_i = 1'b1; bus.s_rsp_valid_i = 1'b1;
    bus.m0_rsp_ready_i = 1'b1; bus.m1_rsp_ready_i = 1'b1;
    #2;
    chk("rst_s_req_valid", 32'(bus.s_req_valid_o), 32'd0);
    chk("rst_m0_ready", 32'(bus.m0_req_ready_o), 32'd0);
    chk("rst_m1_ready", 32'(bus.m1_req_ready_o), 32'd0);
    chk("rst_rsp_valid", 32'({bus.m0_rsp_valid_o, bus.m1_rsp_valid_o}), 32'd0);
    chk("rst_s_rsp_ready", 32'(bus.s_rsp_ready_o), 32'd0);
    chk("rst_s_addr", bus.s_addr_o, 32'd0);
    chk("rst_busy", 32'(bus.busy_o), 32'd0);
    chk("rst_err", 32'(bus.rsp_err_o), 32'd0);
    drive_idle();
    tick();
    rst = 1'b0;

    // T1: single m0 read, response next cycle
    bus.m0_req_valid_i = 1'b1; bus.m0_addr_i = 32'h100; bus.m0_sel_i = 4'hF;
    bus.s_req_ready_i = 1'b1;
    settle();
    chk("t1_grant", 32'(bus.m0_req_ready_o), 32'd1);
    chk("t1_addr", bus.s_addr_o, 32'h100);
    tick();
    drive_idle();
    bus.s_rsp_valid_i = 1'b1; bus.s_rdata_i = 32'hDEADBEEF; bus.m0_rsp_ready_i = 1'b1;
    settle();
    chk("t1_busy_hi", 32'(bus.busy_o), 32'd1);
    chk("t1_rsp_valid", 32'(bus.m0_rsp_valid_o), 32'd1);
    chk("t1_rdata", bus.m0_rdata_o, 32'hDEADBEEF);
    tick();
    drive_idle();
    settle();
    chk("t1_busy_lo", 32'(bus.busy_o), 32'd0);
    tick();

    // T2: m1 priority, m0 forced in after LIMIT m1 accepts
    for (int i = 0; i <= LIMIT; i++) begin
      bus.m0_req_valid_i = 1'b1; bus.m0_addr_i = 32'h200;
      bus.m1_req_valid_i = 1'b1; bus.m1_addr_i = 32'h1000 + i;
      bus.s_req_ready_i = 1'b1;
      bus.s_rsp_valid_i = (exp_q.size() > 0);
      bus.m0_rsp_ready_i = 1'b1; bus.m1_rsp_ready_i = 1'b1;
      settle();
      chk("t2_m1_grant", 32'(bus.m1_req_ready_o), 32'(i < LIMIT));
      chk("t2_m0_grant", 32'(bus.m0_req_ready_o), 32'(i == LIMIT));
      tick();
    end
    drain();

    // T3: stalled m0 grant stays locked while m1 raises valid
    bus.m0_req_valid_i = 1'b1; bus.m0_addr_i = 32'h300; bus.m0_wdata_i = 32'h55;
    bus.m0_we_i = 1'b1; bus.m0_sel_i = 4'h3;
    for (int i = 0; i < 3; i++) begin
      if (i >= 1) begin bus.m1_req_valid_i = 1'b1; bus.m1_addr_i = 32'h400; end
      settle();
      chk("t3_hold_valid", 32'(bus.s_req_valid_o), 32'd1);
      chk("t3_hold_addr", bus.s_addr_o, 32'h300);
      chk("t3_hold_wdata", bus.s_wdata_o, 32'h55);
      chk("t3_m1_blocked", 32'(bus.m1_req_ready_o), 32'd0);
      tick();
    end
    bus.s_req_ready_i = 1'b1;
    settle();
    chk("t3_accept", 32'(bus.m0_req_ready_o), 32'd1);
    tick();
    bus.m0_req_valid_i = 1'b0;
    settle();
    chk("t3_m1_next", 32'(bus.m1_req_ready_o), 32'd1);
    tick();
    drain();

    // T4: fill with m1 then m0, third request blocked, in-order routing
    bus.s_req_ready_i = 1'b1;
    bus.m1_req_valid_i = 1'b1; bus.m1_addr_i = 32'h500;
    settle(); chk("t4_acc_m1", 32'(bus.m1_req_ready_o), 32'd1); tick();
    bus.m1_req_valid_i = 1'b0;
    bus.m0_req_valid_i = 1'b1; bus.m0_addr_i = 32'h600;
    settle(); chk("t4_acc_m0", 32'(bus.m0_req_ready_o), 32'd1); tick();
    bus.m0_req_valid_i = 1'b0;
    bus.m1_req_valid_i = 1'b1; bus.m1_addr_i = 32'h700;
    settle();
    chk("t4_full_valid", 32'(bus.s_req_valid_o), 32'd0);
    chk("t4_full_ready", 32'(bus.m1_req_ready_o), 32'd0);
    tick();
    bus.s_rsp_valid_i = 1'b1; bus.s_rdata_i = 32'h11111111;
    bus.m0_rsp_ready_i = 1'b1; bus.m1_rsp_ready_i = 1'b1;
    settle();
    chk("t4_rsp_m1", 32'(bus.m1_rsp_valid_o), 32'd1);
    chk("t4_rsp_m0_quiet", 32'(bus.m0_rsp_valid_o), 32'd0);
    chk("t4_pop_no_push", 32'(bus.m1_req_ready_o), 32'd0);
    tick();
    bus.s_rdata_i = 32'h22222222;
    settle();
    chk("t4_rsp_m0", 32'(bus.m0_rsp_valid_o), 32'd1);
    chk("t4_rsp_m1_quiet", 32'(bus.m1_rsp_valid_o), 32'd0);
    chk("t4_push_late", 32'(bus.m1_req_ready_o), 32'd1);
    tick();
    drain();

    // T5: response with nothing outstanding
    bus.s_rsp_valid_i = 1'b1; bus.m0_rsp_ready_i = 1'b1; bus.m1_rsp_ready_i = 1'b1;
    settle();
    chk("t5_no_rsp", 32'({bus.m0_rsp_valid_o, bus.m1_rsp_valid_o}), 32'd0);
    tick();
    drive_idle();
    settle(); chk("t5_err_pulse", 32'(bus.rsp_err_o), 32'd1); tick();
    settle(); chk("t5_err_clear", 32'(bus.rsp_err_o), 32'd0); tick();

    // random traffic: masters hold requests until accepted
    pend0 = 1'b0; pend1 = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      if (!pend0 && $urandom_range(0, 2) == 0) begin
        pend0 = 1'b1;
        bus.m0_addr_i = $urandom; bus.m0_wdata_i = $urandom;
        bus.m0_we_i = 1'($urandom); bus.m0_sel_i = 4'($urandom);
      end
      if (!pend1 && $urandom_range(0, 7) < ((c < 750) ? 3 : 7)) begin
        pend1 = 1'b1;
        bus.m1_addr_i = $urandom; bus.m1_wdata_i = $urandom;
        bus.m1_we_i = 1'($urandom); bus.m1_sel_i = 4'($urandom);
      end
      bus.m0_req_valid_i = pend0;
      bus.m1_req_valid_i = pend1;
      bus.s_req_ready_i  = ($urandom_range(0, 3) != 0);
      bus.m0_rsp_ready_i = ($urandom_range(0, 3) != 0);
      bus.m1_rsp_ready_i = ($urandom_range(0, 3) != 0);
      bus.s_rdata_i      = $urandom;
      if (exp_q.size() > 0) bus.s_rsp_valid_i = ($urandom_range(0, 3) != 0);
      else                  bus.s_rsp_valid_i = ($urandom_range(0, 15) == 0);
      settle();
      if (last_acc && last_win == 0) pend0 = 1'b0;
      if (last_acc && last_win == 1) pend1 = 1'b0;
      tick();
    end
    drain();

    // T6: asynchronous reset with two requests outstanding
    bus.s_req_ready_i = 1'b1;
    bus.m1_req_valid_i = 1'b1; bus.m1_addr_i = 32'h810;
    settle(); tick();
    bus.m1_req_valid_i = 1'b0;
    bus.m0_req_valid_i = 1'b1; bus.m0_addr_i = 32'h820;
    settle(); tick();
    bus.m0_req_valid_i = 1'b0;
    bus.m1_req_valid_i = 1'b1; bus.m1_addr_i = 32'h830;
    settle();
    chk("t6_busy_before", 32'(bus.busy_o), 32'd1);
    rst = 1'b1;
    #1;
    chk("t6_busy", 32'(bus.busy_o), 32'd0);
    chk("t6_s_req_valid", 32'(bus.s_req_valid_o), 32'd0);
    chk("t6_req_ready", 32'({bus.m0_req_ready_o, bus.m1_req_ready_o}), 32'd0);
    chk("t6_rsp_valid", 32'({bus.m0_rsp_valid_o, bus.m1_rsp_valid_o}), 32'd0);
    chk("t6_s_rsp_ready", 32'(bus.s_rsp_ready_o), 32'd0);
    chk("t6_s_addr", bus.s_addr_o, 32'd0);
    model_reset();
    drive_idle();
    tick();
    rst = 1'b0;
    settle();
    chk("t6_busy_after", 32'(bus.busy_o), 32'd0);
    tick();
    bus.m0_req_valid_i = 1'b1; bus.m0_addr_i = 32'h900; bus.s_req_ready_i = 1'b1;
    settle();
    chk("t6_post_grant", 32'(bus.m0_req_ready_o), 32'd1);
    tick();
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
